// File: rtl/sys_mem_port_arbiter.sv
// Per-burst arbiter sharing the byte-wide sys memory port between the write and read engines.
// sys_rdata_i is sampled RD_LAT-1 cycles after sys_ren_o, so rd_rvalid_o lands RD_LAT cycles after it.
module sys_mem_port_arbiter #(
    parameter int AXI_AW = 32,
    parameter int RD_LAT = 1
) (
    input  logic              axi_clk_i,
    input  logic              axi_rstn_i,
    input  logic              wr_req_i,
    input  logic              wr_beat_i,
    input  logic [AXI_AW-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic              wr_done_i,
    output logic              wr_gnt_o,
    input  logic              rd_req_i,
    input  logic              rd_beat_i,
    input  logic [AXI_AW-1:0] rd_addr_i,
    input  logic              rd_done_i,
    output logic              rd_gnt_o,
    output logic [7:0]        rd_rdata_o,
    output logic              rd_rvalid_o,
    output logic [AXI_AW-1:0] sys_addr_o,
    output logic [7:0]        sys_wdata_o,
    output logic              sys_wen_o,
    output logic              sys_ren_o,
    input  logic [7:0]        sys_rdata_i,
    output logic              err_drop_o
);

    typedef enum logic [1:0] {IDLE, GNT_WR, GNT_RD, DRAIN} state_e;

    state_e              state_q, state_d;
    logic                last_wr_q, last_wr_d;   // 0 = read engine owned the port last
    logic [RD_LAT-1:0]   vld_pipe_q;
    logic [AXI_AW-1:0]   sys_addr_q;
    logic [7:0]          sys_wdata_q;
    logic                sys_wen_q;
    logic                sys_ren_q;
    logic [7:0]          rd_rdata_q;
    logic                rd_rvalid_q;
    logic                err_q;

    logic wr_acc;
    logic rd_acc;
    logic pipe_busy;
    logic drop;

    assign wr_acc    = (state_q == GNT_WR) && wr_beat_i;
    assign rd_acc    = (state_q == GNT_RD) && rd_beat_i;
    assign pipe_busy = |vld_pipe_q;
    assign drop      = (wr_beat_i && (state_q != GNT_WR)) || (rd_beat_i && (state_q != GNT_RD));

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        case (state_q)
            IDLE: begin
                if (!pipe_busy) begin
                    if (wr_req_i && (!rd_req_i || !last_wr_q)) begin
                        state_d = GNT_WR;
                    end else if (rd_req_i) begin
                        state_d = GNT_RD;
                    end
                end
            end
            GNT_WR: begin
                if (wr_done_i) begin
                    state_d   = IDLE;
                    last_wr_d = 1'b1;
                end
            end
            GNT_RD: begin
                if (rd_done_i) begin
                    state_d   = DRAIN;
                    last_wr_d = 1'b0;
                end
            end
            DRAIN: begin
                // Hold off any new grant until every outstanding read byte has returned.
                if (!pipe_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk_i) begin
        if (!axi_rstn_i) begin
            state_q     <= IDLE;
            last_wr_q   <= 1'b0;
            vld_pipe_q  <= '0;
            sys_addr_q  <= '0;
            sys_wdata_q <= '0;
            sys_wen_q   <= 1'b0;
            sys_ren_q   <= 1'b0;
            rd_rdata_q  <= '0;
            rd_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;

            vld_pipe_q[0] <= rd_acc;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            end

            sys_wen_q <= wr_acc;
            sys_ren_q <= rd_acc;
            if (wr_acc) begin
                sys_addr_q  <= wr_addr_i;
                sys_wdata_q <= wr_data_i;
            end else if (rd_acc) begin
                sys_addr_q  <= rd_addr_i;
            end

            rd_rvalid_q <= vld_pipe_q[RD_LAT-1];
            if (vld_pipe_q[RD_LAT-1]) begin
                rd_rdata_q <= sys_rdata_i;
            end

            if (drop) begin
                err_q <= 1'b1;
            end
        end
    end

    assign wr_gnt_o    = (state_q == GNT_WR);
    assign rd_gnt_o    = (state_q == GNT_RD);
    assign sys_addr_o  = sys_addr_q;
    assign sys_wdata_o = sys_wdata_q;
    assign sys_wen_o   = sys_wen_q;
    assign sys_ren_o   = sys_ren_q;
    assign rd_rdata_o  = rd_rdata_q;
    assign rd_rvalid_o = rd_rvalid_q;
    assign err_drop_o  = err_q;

endmodule
